// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the NTT job sequencer: FSM state encoding,
// error codes and the pair-counter width helper.
package ntt_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ARM       = 4'd1,
        S_LOAD      = 4'd2,
        S_WAIT_IN   = 4'd3,
        S_CALC      = 4'd4,
        S_UNLOAD    = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_GAP     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_EARLY   = 2'd3;

    // One extra bit so the counter can hold N_PAIRS itself without wrapping.
    function automatic int pair_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ntt_sched_wdog.sv
// Watchdog counter for the NTT job sequencer: cleared by clr, counts while en,
// flags expired on the LIMIT-th counted cycle. Saturates instead of wrapping.
module ntt_sched_wdog #(
    parameter int LIMIT = 8192
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ntt_job_sched.sv
// Job-level sequencer in front of the single-butterfly Kyber NTT/INTT core.
// Optional watchdog in WAIT_IN/CALC/WAIT_DONE is built when NTT_SCHED_TIMEOUT_EN is defined.
module ntt_job_sched
    import ntt_sched_pkg::*;
#(
    parameter int DW          = 16,
    parameter int N_PAIRS     = 128,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    input  logic          job_mode,
    output logic          job_ready,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          out_last,
    output logic          core_start,
    output logic          core_mode,
    output logic          core_we,
    output logic [DW-1:0] core_da,
    output logic [DW-1:0] core_db,
    input  logic          core_in_done,
    input  logic          core_cal_done,
    input  logic          core_done,
    input  logic [DW-1:0] core_q1,
    input  logic [DW-1:0] core_q2,
    output logic          busy,
    output logic          job_done,
    output logic          err,
    output logic [1:0]    err_code,
    input  logic          err_clr,
    output logic [3:0]    state_dbg
);

    localparam int             CW   = pair_cnt_w(N_PAIRS);
    localparam logic [CW-1:0]  LAST = CW'(N_PAIRS - 1);

    // Handshakes: a beat transfers on a rising clk edge where valid && ready.
    // job_*: ready only in IDLE. in_*: ready only in LOAD, and the core's
    // free-running address counter makes any gap in LOAD a protocol error.
    // out_*: no backpressure; out_valid simply follows core_cal_done in UNLOAD.

    state_t        state, nxt;
    logic [1:0]    code_nxt;
    logic [CW-1:0] pair_cnt;
    logic          cal_d;
    logic          wd_expired;

`ifdef NTT_SCHED_TIMEOUT_EN
    logic wd_en;
    assign wd_en = (state == S_WAIT_IN) || (state == S_CALC) || (state == S_WAIT_DONE);

    ntt_sched_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_ARM),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    // No watchdog in this build; the comparison is constant-false.
    assign wd_expired = (TIMEOUT_CYC < 0);
`endif

    assign core_we   = in_ready && in_valid;
    assign core_da   = core_we ? in_a : '0;
    assign core_db   = core_we ? in_b : '0;
    assign out_valid = (state == S_UNLOAD) && core_cal_done;
    assign out_a     = out_valid ? core_q1 : '0;
    assign out_b     = out_valid ? core_q2 : '0;
    assign out_last  = out_valid && (pair_cnt == LAST);
    assign state_dbg = state;

    always_comb begin
        nxt      = state;
        code_nxt = ERR_NONE;
        unique case (state)
            S_IDLE: begin
                if (core_cal_done) begin
                    nxt = S_ERR; code_nxt = ERR_EARLY;
                end else if (job_valid && job_ready) begin
                    nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (core_cal_done) begin
                    nxt = S_ERR; code_nxt = ERR_EARLY;
                end else begin
                    nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (core_cal_done) begin
                    nxt = S_ERR; code_nxt = ERR_EARLY;
                end else if (!in_valid) begin
                    nxt = S_ERR; code_nxt = ERR_GAP;
                end else if (pair_cnt == LAST) begin
                    nxt = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (wd_expired) begin
                    nxt = S_ERR; code_nxt = ERR_TIMEOUT;
                end else if (core_in_done) begin
                    nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (wd_expired) begin
                    nxt = S_ERR; code_nxt = ERR_TIMEOUT;
                end else if (core_cal_done && !cal_d) begin
                    nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (out_last) nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (wd_expired) begin
                    nxt = S_ERR; code_nxt = ERR_TIMEOUT;
                end else if (core_done) begin
                    nxt = S_DONE;
                end
            end
            S_DONE:  nxt = S_IDLE;
            S_ERR:   if (err_clr) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pair_cnt   <= '0;
            cal_d      <= 1'b0;
            job_ready  <= 1'b1;
            in_ready   <= 1'b0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state <= nxt;
            cal_d <= core_cal_done;

            if (nxt == S_ARM || (nxt == S_CALC && state != S_CALC)) begin
                pair_cnt <= '0;
            end else if (core_we || out_valid) begin
                pair_cnt <= pair_cnt + 1'b1;
            end

            job_ready  <= (nxt == S_IDLE);
            in_ready   <= (nxt == S_LOAD);
            core_start <= (nxt == S_ARM);
            job_done   <= (nxt == S_DONE);
            busy       <= (nxt != S_IDLE);

            if (nxt == S_IDLE || nxt == S_ERR) begin
                core_mode <= 1'b0;
            end else if (state == S_IDLE) begin
                core_mode <= job_mode;
            end

            // First error wins: the code is captured on entry and held in ERR.
            err <= (nxt == S_ERR);
            if (nxt != S_ERR) begin
                err_code <= ERR_NONE;
            end else if (state != S_ERR) begin
                err_code <= code_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ntt_job_sched.sv
// Self-checking bench for ntt_job_sched: behavioural core model, expected-result
// queue filled from the driven pairs, and directed protocol/error/reset cases.
module tb_ntt_job_sched;
    import ntt_sched_pkg::*;

    localparam int DW = 16;
    localparam int NP = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid, job_mode, job_ready;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_a, in_b;
    logic          out_valid, out_last;
    logic [DW-1:0] out_a, out_b;
    logic          core_start, core_mode, core_we;
    logic [DW-1:0] core_da, core_db;
    logic          core_in_done, core_cal_done, core_done;
    logic [DW-1:0] core_q1, core_q2;
    logic          busy, job_done, err, err_clr;
    logic [1:0]    err_code;
    logic [3:0]    state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   mem_a[NP];
    logic [DW-1:0]   mem_b[NP];
    int wr_idx = 0, out_cnt = 0, start_cnt = 0, done_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1, "simulation time limit");
    end

    ntt_job_sched #(.DW(DW), .N_PAIRS(NP), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_mode(job_mode), .job_ready(job_ready),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_last(out_last),
        .core_start(core_start), .core_mode(core_mode), .core_we(core_we),
        .core_da(core_da), .core_db(core_db),
        .core_in_done(core_in_done), .core_cal_done(core_cal_done), .core_done(core_done),
        .core_q1(core_q1), .core_q2(core_q2),
        .busy(busy), .job_done(job_done), .err(err), .err_code(err_code),
        .err_clr(err_clr), .state_dbg(state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] key(input logic m);
        return m ? 16'h5A5A : 16'h0F0F;
    endfunction

    // Core write capture, pulse counting and output scoreboard.
    always @(negedge clk) begin
        if (core_start) begin
            start_cnt++;
            wr_idx = 0;
        end
        if (job_done) done_cnt++;
        if (core_we && wr_idx < NP) begin
            mem_a[wr_idx] = core_da;
            mem_b[wr_idx] = core_db;
            wr_idx++;
        end
        if (out_valid) begin
            out_cnt++;
            if (exp_q.size() == 0) check("out_extra", out_cnt, 0);
            else check("out_data", {out_a, out_b}, exp_q.pop_front());
            check("out_last", {31'd0, out_last}, {31'd0, out_cnt == NP});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic m);
        out_cnt = 0; start_cnt = 0; done_cnt = 0;
        check("job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_mode  = m;
        tick();
        job_valid = 1'b0;
        job_mode  = ~m;
        check("core_start_arm", core_start, 1);
        check("core_mode_arm", core_mode, m);
        check("busy_arm", busy, 1);
        tick();
        check("in_ready_load", in_ready, 1);
        check("core_start_once", core_start, 0);
        check("core_mode_load", core_mode, m);
    endtask

    task automatic load(input int n, input logic [DW-1:0] base, input logic m);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a = base + DW'(i);
            in_b = base + DW'(i + 128);
            exp_q.push_back({in_a ^ key(m), in_b + 16'd1});
            #1;
            check("core_we", core_we, 1);
            check("core_data", {core_da, core_db}, {in_a, in_b});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Plays the core from WAIT_IN through DONE; stop_at < NP abandons UNLOAD early.
    task automatic finish_job(input logic m, input bit gaps, input int stop_at);
        check("in_ready_wait", in_ready, 0);
        check("core_we_wait", core_we, 0);
        repeat ($urandom_range(1, 3)) tick();
        core_in_done = 1'b1;
        tick();
        core_in_done = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        core_cal_done = 1'b1;
        tick();
        for (int k = 0; k < NP; k++) begin
            if (k == stop_at) return;
            if (gaps && $urandom_range(0, 3) == 0) begin
                core_cal_done = 1'b0;
                core_q1 = DW'($urandom);
                core_q2 = DW'($urandom);
                #1;
                check("gap_out_zero", {out_a, out_b}, 0);
                check("gap_out_valid", out_valid, 0);
                @(posedge clk);
                #1;
            end
            core_cal_done = 1'b1;
            core_q1 = mem_a[k] ^ key(core_mode);
            core_q2 = mem_b[k] + 16'd1;
            tick();
        end
        core_cal_done = 1'b0;
        check("out_count", out_cnt, NP);
        check("core_mode_wait_done", core_mode, m);
        repeat ($urandom_range(0, 2)) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("job_done_pulse", job_done, 1);
        check("core_mode_done", core_mode, m);
        tick();
        check("job_done_clear", job_done, 0);
        check("job_ready_after", job_ready, 1);
        check("busy_after", busy, 0);
        check("core_mode_idle", core_mode, 0);
        check("start_pulses", start_cnt, 1);
        check("done_pulses", done_cnt, 1);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        rst = 1'b0;
        job_valid = 0; job_mode = 0; in_valid = 0; in_a = '0; in_b = '0;
        core_in_done = 0; core_cal_done = 0; core_done = 0;
        core_q1 = '0; core_q2 = '0; err_clr = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err", {29'd0, err, err_code}, 0);
        check("rst_state", state_dbg, S_IDLE);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // NTT job, pairs (i, i+128)
        start_job(1'b0);
        load(NP, 16'd0, 1'b0);
        finish_job(1'b0, 1'b0, NP);

        // INTT job with random data and output gaps
        start_job(1'b1);
        load(NP, DW'($urandom), 1'b1);
        finish_job(1'b1, 1'b1, NP);

        // Input gap at beat 37
        start_job(1'b0);
        load(37, DW'($urandom), 1'b0);
        tick();
        check("gap_err", err, 1);
        check("gap_code", err_code, ERR_GAP);
        check("gap_in_ready", in_ready, 0);
        check("gap_job_ready", job_ready, 0);
        check("gap_state", state_dbg, S_ERR);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_job_ready", job_ready, 1);
        check("clr_err", {30'd0, err, err_code[0]}, 0);
        check("clr_code", err_code, ERR_NONE);
        exp_q.delete();

        // Early cal_done during LOAD; job_valid ignored in ERR
        start_job(1'b1);
        load(10, DW'($urandom), 1'b1);
        in_valid = 1'b1;
        core_cal_done = 1'b1;
        tick();
        in_valid = 1'b0;
        core_cal_done = 1'b0;
        check("early_code", err_code, ERR_EARLY);
        check("early_err", err, 1);
        job_valid = 1'b1;
        repeat (3) tick();
        check("err_hold_state", state_dbg, S_ERR);
        check("err_job_ready", job_ready, 0);
        check("err_hold_code", err_code, ERR_EARLY);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        job_valid = 1'b0;
        check("clr_not_armed", state_dbg, S_IDLE);
        tick();
        check("still_idle", state_dbg, S_IDLE);
        check("no_extra_start", start_cnt, 1);
        exp_q.delete();

        // Core never asserts cal_done
        start_job(1'b0);
        load(NP, DW'($urandom), 1'b0);
        core_in_done = 1'b1;
        tick();
        core_in_done = 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
        waited = 0;
        while (!err && waited < 300) begin
            tick();
            waited++;
        end
        check("wdog_fired", err, 1);
        check("wdog_code", err_code, ERR_TIMEOUT);
`else
        waited = 0;
        repeat (200) begin
            tick();
            waited++;
        end
        check("calc_stays", state_dbg, S_CALC);
        check("calc_no_err", err, 0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();

        // Asynchronous reset mid-UNLOAD at pair 60
        start_job(1'b0);
        load(NP, DW'($urandom), 1'b0);
        finish_job(1'b0, 1'b0, 60);
        check("pre_rst_out_cnt", out_cnt, 60);
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", {out_a, out_b}, 0);
        check("arst_job_ready", job_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_flags", {core_start, core_mode, core_we, in_ready, job_done, err}, 0);
        check("arst_state", state_dbg, S_IDLE);
        core_cal_done = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();

        start_job(1'b1);
        load(NP, DW'($urandom), 1'b1);
        finish_job(1'b1, 1'b1, NP);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
